// File: rtl/pc_next_unit_if.sv
// pc_next_unit_if
// Groups the signals exchanged between the IF-stage program-counter unit and
// the rest of the pipeline (hazard unit, ID and EX redirect sources, exception logic).
//   stall             hazard unit -> PC unit   hold the PC
//   ID_HazardControl  ID -> PC unit            ID-stage redirect request
//   ID_PC             ID -> PC unit            ID-stage redirect target
//   EX_redirect       EX -> PC unit            EX-stage redirect (mispredict)
//   EX_target         EX -> PC unit            EX-stage redirect target
//   exc_req           exception -> PC unit     load the exception vector
//   pc                PC unit -> IF            current fetch PC (registered)
//   pc_plus           PC unit -> IF            pc + increment (combinational)
//   fetch_valid       PC unit -> IF/ID         fetch at pc is architecturally valid
//   redirect_pending  PC unit -> pipeline      a buffered redirect waits for stall release
// Modports: master = pipeline side that drives requests, slave = the PC unit.
interface pc_next_unit_if #(
  parameter int PC_WIDTH = 16
);
  logic                stall;
  logic                ID_HazardControl;
  logic [PC_WIDTH-1:0] ID_PC;
  logic                EX_redirect;
  logic [PC_WIDTH-1:0] EX_target;
  logic                exc_req;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus;
  logic                fetch_valid;
  logic                redirect_pending;

  modport master (
    output stall, ID_HazardControl, ID_PC, EX_redirect, EX_target, exc_req,
    input  pc, pc_plus, fetch_valid, redirect_pending
  );

  modport slave (
    input  stall, ID_HazardControl, ID_PC, EX_redirect, EX_target, exc_req,
    output pc, pc_plus, fetch_valid, redirect_pending
  );
endinterface

// File: rtl/pc_next_unit.sv
// pc_next_unit
// Program-counter generator for the IF stage. Owns the PC register and picks
// the next PC from: exception vector, EX redirect, ID redirect, a buffered
// redirect, hold (stall) or sequential increment, in that priority order.
// A redirect that arrives while stalled is buffered and applied on the first
// unstalled cycle. Every applied redirect squashes FLUSH_SLOTS fetch cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pc_next_unit_if.slave (requests in, pc/pc_plus/fetch_valid/redirect_pending out)
//   redirect_count  16-bit saturating count of applied redirects/exceptions,
//                   present only when PC_REDIRECT_COUNT_EN is defined
// Optional feature macro: PC_REDIRECT_COUNT_EN
module pc_next_unit #(
  parameter int          PC_WIDTH     = 16,
  parameter int          PC_INC       = 1,
  parameter int          RESET_VECTOR = 0,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_FF00,
  parameter int          FLUSH_SLOTS  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_next_unit_if.slave      bus
`ifdef PC_REDIRECT_COUNT_EN
  ,
  output logic [15:0]        redirect_count
`endif
);

  localparam logic [1:0] STATE_RUN       = 2'd0;
  localparam logic [1:0] STATE_FLUSH     = 2'd1;
  localparam logic [1:0] STATE_HOLD_PEND = 2'd2;

  localparam logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] EXC_PC    = PC_WIDTH'(EXC_VECTOR);
  localparam logic [PC_WIDTH-1:0] INC_PC    = PC_WIDTH'(PC_INC);
  localparam logic [1:0]          FLUSH_INIT = 2'(FLUSH_SLOTS);

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pcReg;
  logic [PC_WIDTH-1:0] pendTarget;
  logic [1:0]          flushCnt;
  logic                fetchValid;

  logic                redirectReq;
  logic [PC_WIDTH-1:0] redirectTarget;
  logic                loadPc;
  logic [PC_WIDTH-1:0] loadTarget;

  // EX is older in program order than ID, so its redirect takes precedence.
  assign redirectReq    = bus.EX_redirect | bus.ID_HazardControl;
  assign redirectTarget = bus.EX_redirect ? bus.EX_target : bus.ID_PC;

  assign bus.pc               = pcReg;
  assign bus.pc_plus          = pcReg + INC_PC;
  assign bus.fetch_valid      = fetchValid;
  assign bus.redirect_pending = (state == STATE_HOLD_PEND);

  // Decide whether this edge loads a non-sequential target into the PC.
  // Exceptions ignore stall; a fresh redirect beats the buffered one.
  always_comb begin
    loadPc     = 1'b0;
    loadTarget = redirectTarget;
    if (bus.exc_req) begin
      loadPc     = 1'b1;
      loadTarget = EXC_PC;
    end else if (redirectReq && !bus.stall) begin
      loadPc = 1'b1;
    end else if (!redirectReq && (state == STATE_HOLD_PEND) && !bus.stall) begin
      loadPc     = 1'b1;
      loadTarget = pendTarget;
    end
  end

  // PC register and RUN/FLUSH/HOLD_PEND control. Straight out of reset the
  // state is RUN with fetchValid low: the first unstalled edge only marks the
  // reset-vector fetch valid instead of advancing, so RESET_VECTOR is fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= STATE_RUN;
      pcReg      <= RESET_PC;
      pendTarget <= '0;
      flushCnt   <= 2'd0;
      fetchValid <= 1'b0;
    end else if (loadPc) begin
      pcReg <= loadTarget;
      if (FLUSH_SLOTS == 0) begin
        state      <= STATE_RUN;
        flushCnt   <= 2'd0;
        fetchValid <= 1'b1;
      end else begin
        state      <= STATE_FLUSH;
        flushCnt   <= FLUSH_INIT;
        fetchValid <= 1'b0;
      end
    end else if (redirectReq) begin
      // Only reachable while stalled: buffer the target, newest wins.
      pendTarget <= redirectTarget;
      state      <= STATE_HOLD_PEND;
    end else if (!bus.stall) begin
      case (state)
        STATE_FLUSH: begin
          pcReg <= bus.pc_plus;
          if (flushCnt == 2'd1) begin
            state      <= STATE_RUN;
            flushCnt   <= 2'd0;
            fetchValid <= 1'b1;
          end else begin
            flushCnt <= flushCnt - 2'd1;
          end
        end
        default: begin
          if (fetchValid) begin
            pcReg <= bus.pc_plus;
          end else begin
            fetchValid <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PC_REDIRECT_COUNT_EN
  // Counts PC loads from redirect/exception targets; a buffered redirect is
  // counted when it is applied, not when it is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count <= 16'd0;
    end else if (loadPc && (redirect_count != 16'hFFFF)) begin
      redirect_count <= redirect_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit
// Self-checking bench for pc_next_unit (PC_WIDTH=16, PC_INC=1,
// RESET_VECTOR=1000, FLUSH_SLOTS=1). A behavioural model tracks pc, squash
// slots and the buffered redirect; directed sequences cover the key cases,
// then randomized requests, stalls and async resets run against the model.
// Optional feature macro: PC_REDIRECT_COUNT_EN
module tb_pc_next_unit;
  localparam int W  = 16;
  localparam int RV = 1000;
  localparam int FS = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_next_unit_if #(.PC_WIDTH(W)) bus ();
`ifdef PC_REDIRECT_COUNT_EN
  logic [15:0] redirectCount;
`endif

  pc_next_unit #(
    .PC_WIDTH(W), .PC_INC(1), .RESET_VECTOR(RV),
    .EXC_VECTOR(32'h0000_FF00), .FLUSH_SLOTS(FS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef PC_REDIRECT_COUNT_EN
    ,
    .redirect_count(redirectCount)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: plain integers, not the RTL encoding.
  int mPc;
  int mPendTarget;
  bit mPend;
  bit mFv;
  bit mStarted;
  int mSquash;
  int mCount;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPc = RV; mPendTarget = 0; mPend = 0; mFv = 0; mStarted = 0; mSquash = 0; mCount = 0;
  endtask

  task automatic modelLoad(input int target);
    mPc      = target;
    mSquash  = FS;
    mFv      = (FS == 0);
    mStarted = 1;
    mPend    = 0;
    if (mCount < 65535) mCount++;
  endtask

  // One rising edge of the reference: priority exc > EX > ID > buffer > stall > sequential.
  task automatic modelEdge(input bit st, input bit id, input int idPc, input bit ex, input int exT, input bit exc);
    bit redir;
    int target;
    redir  = ex | id;
    target = ex ? exT : idPc;
    if (exc) modelLoad(32'hFF00);
    else if (redir && st) begin
      mPend = 1;
      mPendTarget = target;
    end
    else if (redir) modelLoad(target);
    else if (mPend && !st) modelLoad(mPendTarget);
    else if (st || mPend) begin end
    else if (!mStarted) begin
      mStarted = 1;
      mFv = 1;
    end else begin
      mPc = (mPc + 1) % 65536;
      if (mSquash > 0) mSquash--;
      mFv = (mSquash == 0);
    end
  endtask

  task automatic compareAll();
    checkOutput("pc", bus.pc, 32'(mPc));
    checkOutput("pcPlus", bus.pc_plus, 32'((mPc + 1) % 65536));
    checkOutput("fetchValid", bus.fetch_valid, 32'(mFv));
    checkOutput("pending", bus.redirect_pending, 32'(mPend));
`ifdef PC_REDIRECT_COUNT_EN
    checkOutput("count", redirectCount, 32'(mCount));
`endif
  endtask

  task automatic applyStimulus(input bit st, input bit id, input logic [15:0] idPc,
                               input bit ex, input logic [15:0] exT, input bit exc);
    bus.stall = st; bus.ID_HazardControl = id; bus.ID_PC = idPc;
    bus.EX_redirect = ex; bus.EX_target = exT; bus.exc_req = exc;
    @(posedge clk);
    modelEdge(st, id, int'(idPc), ex, int'(exT), exc);
    #1;
    compareAll();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
  endtask

  // Asynchronous reset pulled away from any clock edge; outputs must drop at once.
  task automatic asyncReset(input string tag);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, "Pc"}, bus.pc, 32'd1000);
    checkOutput({tag, "Fv"}, bus.fetch_valid, 32'd0);
    checkOutput({tag, "Pend"}, bus.redirect_pending, 32'd0);
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall = 0; bus.ID_HazardControl = 0; bus.ID_PC = '0;
    bus.EX_redirect = 0; bus.EX_target = '0; bus.exc_req = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstPc", bus.pc, 32'd1000);
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running start: 1000 fetched first, then sequential.
    idle(); checkOutput("t1pc0", bus.pc, 32'd1000); checkOutput("t1fv", bus.fetch_valid, 32'd1);
    idle(); checkOutput("t1pc1", bus.pc, 32'd1001);
    idle(); checkOutput("t1pc2", bus.pc, 32'd1002);
    idle(); checkOutput("t1pc3", bus.pc, 32'd1003);

    // ID redirect with one squashed slot.
    applyStimulus(0, 1, 16'd1500, 0, 16'd0, 0);
    checkOutput("t2pc", bus.pc, 32'd1500); checkOutput("t2fv0", bus.fetch_valid, 32'd0);
    idle();
    checkOutput("t2pcNext", bus.pc, 32'd1501); checkOutput("t2fv1", bus.fetch_valid, 32'd1);

    // EX beats ID; exception beats everything, even stall.
    applyStimulus(0, 1, 16'd1500, 1, 16'd2000, 0);
    checkOutput("t3ex", bus.pc, 32'd2000);
    applyStimulus(1, 1, 16'd1500, 1, 16'd2000, 1);
    checkOutput("t3exc", bus.pc, 32'hFF00);
    idle(); idle();

    // Buffered redirects under stall, newest wins.
    applyStimulus(1, 1, 16'd1500, 0, 16'd0, 0);
    checkOutput("t4pend", bus.redirect_pending, 32'd1);
    applyStimulus(1, 0, 16'd0, 0, 16'd0, 0);
    applyStimulus(1, 1, 16'd1600, 0, 16'd0, 0);
    checkOutput("t4held", bus.pc, 32'hFF02);
    applyStimulus(0, 0, 16'd0, 0, 16'd0, 0);
    checkOutput("t4pc", bus.pc, 32'd1600); checkOutput("t4pendClr", bus.redirect_pending, 32'd0);
    checkOutput("t4squash", bus.fetch_valid, 32'd0);
    idle();
    checkOutput("t4pcNext", bus.pc, 32'd1601);

    // Wrap-around, then reset while flushing and while pending.
    applyStimulus(0, 0, 16'd0, 1, 16'hFFFE, 0);
    idle(); checkOutput("t5ffff", bus.pc, 32'hFFFF);
    idle(); checkOutput("t5wrap", bus.pc, 32'h0000);
    idle(); checkOutput("t5one", bus.pc, 32'h0001);
    applyStimulus(0, 0, 16'd0, 1, 16'h1234, 0);
    asyncReset("t5rstFlush");
    idle();
    applyStimulus(1, 1, 16'h0777, 0, 16'd0, 0);
    asyncReset("t5rstPend");

`ifdef PC_REDIRECT_COUNT_EN
    idle();
    applyStimulus(0, 1, 16'd100, 0, 16'd0, 0);
    applyStimulus(0, 0, 16'd0, 1, 16'd200, 0);
    applyStimulus(1, 1, 16'd300, 0, 16'd0, 0);
    checkOutput("t6buffered", redirectCount, 32'd2);
    idle();
    applyStimulus(0, 0, 16'd0, 0, 16'd0, 1);
    checkOutput("t6count", redirectCount, 32'd4);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        asyncReset("rndRst");
      end else begin
        applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, 16'($urandom),
                      $urandom_range(0, 11) == 0, 16'($urandom), $urandom_range(0, 29) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
